// File: rtl/rpm_pkg.sv
// Shared types and constants for the rpm_window_ctrl Hall-sensor speed path.
package rpm_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARM   = 2'd1,
    COUNT = 2'd2,
    SCALE = 2'd3
  } rpm_state_e;

  localparam int unsigned RPM_SCALE = 60;
  localparam int unsigned WIN_SEL_W = 2;
  localparam int unsigned RPM_W     = 16;
  localparam logic [RPM_W-1:0] RPM_SAT = 16'hFFFF;
  localparam int unsigned MULT_W    = 9;

  // Edges-per-window to RPM factor: 60 per second of window, window shrinks by 2^sel.
  function automatic logic [MULT_W-1:0] rpm_mult(input logic [WIN_SEL_W-1:0] sel);
    logic [MULT_W-1:0] base;
    base = MULT_W'(RPM_SCALE);
    return base << sel;
  endfunction

endpackage

// File: rtl/rpm_edge_sync.sv
// Two-flop synchronizer for an asynchronous pin plus a registered one-cycle
// rising-edge pulse; pin change to pulse is three clock edges.
module rpm_edge_sync (
  input  logic clock,
  input  logic reset,
  input  logic async_i,
  output logic sync_o,
  output logic rise_o
);

  logic meta_q;
  logic sync_q;
  logic prev_q;
  logic rise_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
      prev_q <= 1'b0;
      rise_q <= 1'b0;
    end else begin
      meta_q <= async_i;
      sync_q <= meta_q;
      prev_q <= sync_q;
      rise_q <= sync_q & ~prev_q;
    end
  end

  assign sync_o = sync_q;
  assign rise_o = rise_q;

endmodule

// File: rtl/rpm_window_ctrl.sv
// Measurement-window controller: counts synchronized SA rises over a gated window,
// scales to RPM and hands the result out via valid/ready. Macro RPM_DIR_DETECT_EN adds SB direction.
module rpm_window_ctrl
  import rpm_pkg::*;
#(
  parameter int unsigned CLK_HZ = 100_000_000,
  parameter int unsigned CNT_W  = 16
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 enable,
  input  logic [WIN_SEL_W-1:0] win_sel,
  input  logic                 sa_input,
  input  logic                 sb_input,
  output logic [RPM_W-1:0]     rpm_output,
  output logic                 rpm_dir,
  output logic                 rpm_valid,
  input  logic                 rpm_ready,
  output logic                 overflow,
  output logic                 overrun,
  output logic                 busy
);

  localparam int unsigned WIN_W  = $clog2(CLK_HZ + 1);
  localparam int unsigned PROD_W = CNT_W + MULT_W;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  rpm_state_e           state_q;
  logic [WIN_SEL_W-1:0] sel_q;
  logic [WIN_W-1:0]     win_q;
  logic [CNT_W-1:0]     cnt_q;
  logic [CNT_W-1:0]     cnt_inc;
  logic [RPM_W-1:0]     rpm_q;
  logic [RPM_W-1:0]     rpm_d;
  logic [PROD_W-1:0]    prod;
  logic                 dir_q;
  logic                 dir_d;
  logic                 valid_q;
  logic                 ovf_q;
  logic                 ovf_d;
  logic                 overrun_q;
  logic                 sa_rise;
  logic                 sa_sync_unused;

  function automatic logic [WIN_W-1:0] win_load(input logic [WIN_SEL_W-1:0] sel);
    int unsigned len;
    len = (CLK_HZ >> sel) - 1;
    return len[WIN_W-1:0];
  endfunction

  rpm_edge_sync u_sa_sync (
    .clock   (clock),
    .reset   (reset),
    .async_i (sa_input),
    .sync_o  (sa_sync_unused),
    .rise_o  (sa_rise)
  );

`ifdef RPM_DIR_DETECT_EN
  logic sb_sync;
  logic sb_rise_unused;
  logic sb_last_q;

  rpm_edge_sync u_sb_sync (
    .clock   (clock),
    .reset   (reset),
    .async_i (sb_input),
    .sync_o  (sb_sync),
    .rise_o  (sb_rise_unused)
  );

  // SB captured at every counted SA rise; the last one in the window wins.
  always_ff @(posedge clock) begin
    if (reset) begin
      sb_last_q <= 1'b0;
    end else if (sa_rise && (state_q == COUNT || state_q == SCALE)) begin
      sb_last_q <= sb_sync;
    end
  end

  assign dir_d = (cnt_q != '0) ? sb_last_q : dir_q;
`else
  logic unused_sb;
  assign unused_sb = sb_input;
  assign dir_d     = 1'b0;
`endif

  always_comb begin
    prod    = PROD_W'(cnt_q) * PROD_W'(rpm_mult(sel_q));
    ovf_d   = (cnt_q == CNT_MAX) || (prod > PROD_W'(RPM_SAT));
    rpm_d   = ovf_d ? RPM_SAT : prod[RPM_W-1:0];
    cnt_inc = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= IDLE;
      sel_q     <= '0;
      win_q     <= '0;
      cnt_q     <= '0;
      rpm_q     <= '0;
      dir_q     <= 1'b0;
      valid_q   <= 1'b0;
      ovf_q     <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      overrun_q <= 1'b0;
      if (valid_q && rpm_ready) begin
        valid_q <= 1'b0;
      end
      unique case (state_q)
        IDLE: begin
          win_q <= '0;
          cnt_q <= '0;
          if (enable) begin
            state_q <= ARM;
          end
        end
        ARM: begin
          sel_q   <= win_sel;
          win_q   <= win_load(win_sel);
          cnt_q   <= '0;
          state_q <= COUNT;
        end
        COUNT: begin
          if (!enable) begin
            state_q <= IDLE;
          end else begin
            if (sa_rise) begin
              cnt_q <= cnt_inc;
            end
            if (win_q == '0) begin
              state_q <= SCALE;
            end else begin
              win_q <= win_q - WIN_W'(1);
            end
          end
        end
        SCALE: begin
          // Result write overrides the handshake clear above; overrun only if nobody took the old one.
          rpm_q     <= rpm_d;
          ovf_q     <= ovf_d;
          dir_q     <= dir_d;
          valid_q   <= 1'b1;
          overrun_q <= valid_q && !rpm_ready;
          sel_q     <= win_sel;
          win_q     <= win_load(win_sel);
          cnt_q     <= sa_rise ? CNT_W'(1) : '0;
          state_q   <= enable ? COUNT : IDLE;
        end
      endcase
    end
  end

  assign rpm_output = rpm_q;
  assign rpm_dir    = dir_q;
  assign rpm_valid  = valid_q;
  assign overflow   = ovf_q;
  assign overrun    = overrun_q;
  assign busy       = (state_q != IDLE);

endmodule

// File: tb/tb_rpm_window_ctrl.sv
// Randomized self-checking bench for rpm_window_ctrl with a small clock rate and
// a narrow edge counter so both overflow sources are reachable.
module tb_rpm_window_ctrl;

  localparam int unsigned CLK_HZ  = 4096;
  localparam int unsigned CNT_W   = 10;
  localparam int unsigned CNT_MAX = (1 << CNT_W) - 1;

  logic        clock = 1'b0;
  logic        reset;
  logic        enable;
  logic [1:0]  win_sel;
  logic        sa_input;
  logic        sb_input;
  logic [15:0] rpm_output;
  logic        rpm_dir;
  logic        rpm_valid;
  logic        rpm_ready;
  logic        overflow;
  logic        overrun;
  logic        busy;

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;

  // Reference state: what the outputs must currently show.
  logic        m_valid;
  logic        m_over;
  logic        m_dir;
  logic        m_ovf;
  logic [15:0] m_rpm;

  rpm_window_ctrl #(.CLK_HZ(CLK_HZ), .CNT_W(CNT_W)) dut (
    .clock      (clock),
    .reset      (reset),
    .enable     (enable),
    .win_sel    (win_sel),
    .sa_input   (sa_input),
    .sb_input   (sb_input),
    .rpm_output (rpm_output),
    .rpm_dir    (rpm_dir),
    .rpm_valid  (rpm_valid),
    .rpm_ready  (rpm_ready),
    .overflow   (overflow),
    .overrun    (overrun),
    .busy       (busy)
  );

  always #5 clock = ~clock;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // One clock; apply the valid/ready rules to the model, then compare.
  task automatic step(input bit wrote, input bit exp_busy);
    @(posedge clock);
    #1;
    if (wrote) begin
      m_over  = m_valid && !rpm_ready;
      m_valid = 1'b1;
    end else begin
      m_over = 1'b0;
      if (m_valid && rpm_ready) m_valid = 1'b0;
    end
    check_eq("valid",   32'(rpm_valid), 32'(m_valid));
    check_eq("overrun", 32'(overrun),   32'(m_over));
    check_eq("busy",    32'(busy),      32'(exp_busy));
  endtask

  task automatic idle(input int unsigned n);
    for (int unsigned i = 0; i < n; i++) step(1'b0, 1'b0);
  endtask

  task automatic check_all(input string tag);
    check_eq({tag, "_rpm"},  32'(rpm_output), 32'(m_rpm));
    check_eq({tag, "_ovf"},  32'(overflow),   32'(m_ovf));
    check_eq({tag, "_dir"},  32'(rpm_dir),    32'(m_dir));
  endtask

  // RPM = edges * 60 * 2^sel, clipped to 16 bits; a full edge counter also clips.
  task automatic expect_result(input int unsigned sel, input int unsigned edges, input bit sbv);
    int unsigned c;
    int unsigned v;
    bit          sat;
    c     = (edges > CNT_MAX) ? CNT_MAX : edges;
    sat   = (edges >= CNT_MAX);
    v     = c * 60 * (1 << sel);
    m_ovf = sat || (v > 65535);
    m_rpm = m_ovf ? 16'hFFFF : v[15:0];
`ifdef RPM_DIR_DETECT_EN
    if (edges != 0) m_dir = sbv;
`else
    m_dir = sbv & 1'b0;
`endif
    check_all("result");
  endtask

  // From IDLE: raise enable, pass ARM, land at the first COUNT cycle.
  task automatic start_run(input int unsigned sel);
    win_sel = 2'(sel);
    enable  = 1'b1;
    step(1'b0, 1'b1);
    step(1'b0, 1'b1);
  endtask

  // One full window (N COUNT cycles + SCALE). Called at the first COUNT cycle.
  task automatic run_window(input int unsigned sel, input int unsigned npulse, input bit sbv,
                            input bit toggle, input bit ready_rand, input bit last,
                            input int unsigned next_sel);
    int unsigned n;
    int unsigned edges;
    int unsigned next_rise;
    int unsigned hi_until;
    bit          nv;
    n         = CLK_HZ >> sel;
    edges     = 0;
    hi_until  = 0;
    next_rise = $urandom_range(12, 0);
    for (int unsigned p = 0; p <= n; p++) begin
      sb_input = sbv;
      if (toggle) begin
        nv = (p + 12 < n) && p[0];
        if (nv && !sa_input) edges++;
        sa_input = nv;
      end else if (p == next_rise && edges < npulse && p + 12 <= n) begin
        sa_input  = 1'b1;
        edges++;
        hi_until  = p + 2;
        next_rise = p + $urandom_range(7, 4);
      end else if (p >= hi_until) begin
        sa_input = 1'b0;
      end
      rpm_ready = ready_rand ? ($urandom_range(3, 0) == 0) : 1'b0;
      if (p == n / 2) win_sel = 2'($urandom_range(3, 0));
      if (p == n) begin
        win_sel = 2'(next_sel);
        enable  = !last;
      end
      step(p == n, (p == n) ? !last : 1'b1);
    end
    expect_result(sel, edges, sbv);
  endtask

  initial begin
    int unsigned nw;
    int unsigned sel;
    int unsigned nsel;
    reset     = 1'b1;
    enable    = 1'b0;
    win_sel   = 2'd0;
    sa_input  = 1'b0;
    sb_input  = 1'b0;
    rpm_ready = 1'b0;
    m_valid   = 1'b0;
    m_over    = 1'b0;
    m_dir     = 1'b0;
    m_ovf     = 1'b0;
    m_rpm     = 16'h0;
    repeat (3) @(posedge clock);
    #1;
    check_all("reset");
    check_eq("reset_valid",   32'(rpm_valid), 32'(0));
    check_eq("reset_overrun", 32'(overrun),   32'(0));
    check_eq("reset_busy",    32'(busy),      32'(0));
    reset = 1'b0;
    idle(3);

    // 10 pulses in a full window, then a one-cycle ready
    start_run(0);
    run_window(0, 10, 1'b1, 1'b0, 1'b0, 1'b1, 0);
    rpm_ready = 1'b1;
    step(1'b0, 1'b0);
    rpm_ready = 1'b0;
    idle(2);

    // quarter window, 5 pulses
    start_run(2);
    run_window(2, 5, 1'b0, 1'b0, 1'b0, 1'b1, 0);
    rpm_ready = 1'b1;
    step(1'b0, 1'b0);
    rpm_ready = 1'b0;

    // SA toggling every cycle: counter saturation, then product overflow
    start_run(0);
    run_window(0, 0, 1'b0, 1'b1, 1'b0, 1'b1, 0);
    idle(2);
    start_run(3);
    run_window(3, 0, 1'b0, 1'b1, 1'b1, 1'b1, 0);
    idle(2);

    // zero-edge window keeps the previous direction
    start_run(3);
    run_window(3, 0, 1'b1, 1'b0, 1'b1, 1'b1, 0);
    idle(2);

    // two back-to-back windows with ready low: overrun on the second write
    rpm_ready = 1'b0;
    start_run(0);
    run_window(0, 3, 1'b1, 1'b0, 1'b0, 1'b0, 0);
    run_window(0, 4, 1'b1, 1'b0, 1'b0, 1'b1, 0);
    idle(2);

    for (int r = 0; r < 8; r++) begin
      nw  = $urandom_range(3, 1);
      sel = $urandom_range(3, 1);
      start_run(sel);
      for (int unsigned w = 0; w < nw; w++) begin
        nsel = $urandom_range(3, 1);
        run_window(sel, $urandom_range((CLK_HZ >> sel) / 8, 0), 1'($urandom_range(1, 0)),
                   1'b0, 1'b1, w == nw - 1, nsel);
        sel = nsel;
      end
      idle(2);
    end

    // abort mid-COUNT: no result, outputs held
    rpm_ready = 1'b0;
    start_run(1);
    for (int unsigned p = 0; p < 100; p++) begin
      sa_input = (p % 8) < 2;
      step(1'b0, 1'b1);
    end
    enable   = 1'b0;
    sa_input = 1'b0;
    step(1'b0, 1'b0);
    check_all("abort");
    idle(6);

    // reset mid-COUNT with a pending result
    start_run(3);
    run_window(3, 6, 1'b1, 1'b0, 1'b0, 1'b0, 3);
    for (int unsigned p = 0; p < 40; p++) begin
      sa_input = (p % 8) < 2;
      step(1'b0, 1'b1);
    end
    reset    = 1'b1;
    enable   = 1'b0;
    sa_input = 1'b0;
    @(posedge clock);
    #1;
    reset   = 1'b0;
    m_valid = 1'b0;
    m_over  = 1'b0;
    m_dir   = 1'b0;
    m_ovf   = 1'b0;
    m_rpm   = 16'h0;
    check_all("midreset");
    check_eq("midreset_valid", 32'(rpm_valid), 32'(0));
    check_eq("midreset_busy",  32'(busy),      32'(0));
    idle(4);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
